// File: rtl/ldsel_ctrl_if.sv
// ldsel_ctrl_if: request, memory-read and response signals of the load-path controller.
`default_nettype none

interface ldsel_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_signed;

  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  // Controller side.
  modport slave (
    input  req_valid, req_addr, req_size, req_signed,
    input  mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_rd, mem_addr,
    output rsp_valid, rsp_data, rsp_err
  );

  // Core plus memory side.
  modport master (
    output req_valid, req_addr, req_size, req_signed,
    output mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_rd, mem_addr,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/ldsel_ctrl.sv
// ldsel_ctrl: one-at-a-time load controller with byte/halfword lane select and extension.
// Revision 1.0
`default_nettype none

module ldsel_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    rst,
  ldsel_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [1:0]            lo_addr;
  logic [1:0]            lo_addr_next;
  logic [1:0]            size;
  logic [1:0]            size_next;
  logic                  sgn;
  logic                  sgn_next;

  logic                  mem_rd;
  logic                  mem_rd_next;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic                  rsp_valid;
  logic                  rsp_valid_next;
  logic [31:0]           rsp_data;
  logic [31:0]           rsp_data_next;
  logic                  rsp_err;
  logic                  rsp_err_next;

  logic                  req_bad;
  logic [31:0]           load_result;

  function automatic logic [31:0] extract_lane(
    input logic [31:0] word,
    input logic [1:0]  a,
    input logic [1:0]  sz,
    input logic        s
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (sz)
      2'd0:    extract_lane = {{24{s & b[7]}}, b};
      2'd1:    extract_lane = {{16{s & h[15]}}, h};
      default: extract_lane = word;
    endcase
  endfunction

  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      2'd1:    req_bad = bus.req_addr[0];
      2'd2:    req_bad = |bus.req_addr[1:0];
      2'd3:    req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  assign load_result = extract_lane(bus.mem_rdata, lo_addr, size, sgn);

  always_comb begin
    state_next     = state;
    lo_addr_next   = lo_addr;
    size_next      = size;
    sgn_next       = sgn;
    mem_rd_next    = mem_rd;
    mem_addr_next  = mem_addr;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          lo_addr_next = bus.req_addr[1:0];
          size_next    = bus.req_size;
          sgn_next     = bus.req_signed;
          rsp_err_next = 1'b0;
          if (req_bad) begin
            // Rejected requests never touch memory; answer straight away.
            state_next     = RSP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_data_next  = 32'd0;
          end else begin
            state_next    = MEM;
            mem_rd_next   = 1'b1;
            mem_addr_next = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          state_next     = RSP;
          mem_rd_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_data_next  = load_result;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        mem_rd_next    = 1'b0;
        rsp_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lo_addr   <= 2'd0;
      size      <= 2'd0;
      sgn       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      lo_addr   <= lo_addr_next;
      size      <= size_next;
      sgn       <= sgn_next;
      mem_rd    <= mem_rd_next;
      mem_addr  <= mem_addr_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_addr  = mem_addr;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_ldsel_ctrl.sv
// tb_ldsel_ctrl: directed self-checking bench for the load-path controller.
`default_nettype none

module tb_ldsel_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ldsel_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  ldsel_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Drives one request, answers memory after 'delay' idle cycles, consumes the response.
  // lat counts clock edges from the accept edge to the first cycle rsp_valid is seen.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] rdata, input int delay,
                          output logic [31:0] data, output logic err,
                          output logic [31:0] maddr, output logic mrd, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    lat   = 1;
    mrd   = bus.mem_rd;
    maddr = bus.mem_addr;
    if (mrd) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        lat++;
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      @(negedge clk);
      lat++;
      bus.mem_ack = 1'b0;
    end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      lat++;
      n++;
    end
    data = bus.rsp_data;
    err  = bus.rsp_err;
    if (!bus.rsp_valid) lat = -1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_addr = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0; bus.rsp_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte_sweep();
    logic [31:0] exp_u [4];
    logic [31:0] exp_s [4];
    logic [31:0] d, ma;
    logic        e, mr;
    int          lat;
    exp_u[0] = 32'h0000000C; exp_u[1] = 32'h000000FD; exp_u[2] = 32'h0000008E; exp_u[3] = 32'h00000078;
    exp_s[0] = 32'h0000000C; exp_s[1] = 32'hFFFFFFFD; exp_s[2] = 32'hFFFFFF8E; exp_s[3] = 32'h00000078;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        run_load(32'h40 + 32'(a), 2'd0, s[0], 32'h788EFD0C, 0, d, e, ma, mr, lat);
        checks++;
        if (d !== (s == 0 ? exp_u[a] : exp_s[a]) || e !== 1'b0) begin
          errors++;
          $display("FAIL byte_a%0d_s%0d got data %h err %b want %h err 0", a, s, d, e,
                   (s == 0 ? exp_u[a] : exp_s[a]));
        end
        checks++;
        if (ma !== 32'h40 || mr !== 1'b1 || lat != 2) begin
          errors++;
          $display("FAIL byte_mem_a%0d_s%0d got addr %h rd %b lat %0d want 00000040 1 2", a, s, ma, mr, lat);
        end
      end
    end
  endtask

  task automatic test_half_word();
    logic [31:0] d, ma;
    logic        e, mr;
    int          lat;
    run_load(32'h102, 2'd1, 1'b1, 32'h788EFD0C, 0, d, e, ma, mr, lat);
    checks++; if (d !== 32'h0000788E || ma !== 32'h100) begin errors++; $display("FAIL half_hi_signed got %h addr %h want 0000788E addr 00000100", d, ma); end
    run_load(32'h100, 2'd1, 1'b1, 32'h788EFD0C, 0, d, e, ma, mr, lat);
    checks++; if (d !== 32'hFFFFFD0C) begin errors++; $display("FAIL half_lo_signed got %h want FFFFFD0C", d); end
    run_load(32'h100, 2'd1, 1'b0, 32'h788EFD0C, 0, d, e, ma, mr, lat);
    checks++; if (d !== 32'h0000FD0C) begin errors++; $display("FAIL half_lo_unsigned got %h want 0000FD0C", d); end
    run_load(32'h104, 2'd2, 1'b0, 32'h788EFD0C, 0, d, e, ma, mr, lat);
    checks++; if (d !== 32'h788EFD0C || ma !== 32'h104 || e !== 1'b0) begin errors++; $display("FAIL word got %h addr %h err %b want 788EFD0C 00000104 0", d, ma, e); end
    run_load(32'h108, 2'd2, 1'b1, 32'h80000001, 2, d, e, ma, mr, lat);
    checks++; if (d !== 32'h80000001 || lat != 4) begin errors++; $display("FAIL word_signed got %h lat %0d want 80000001 lat 4", d, lat); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    logic [31:0] d, ma;
    logic        e, mr;
    int          lat;
    addrs[0] = 32'h101; sizes[0] = 2'd2;
    addrs[1] = 32'h103; sizes[1] = 2'd1;
    addrs[2] = 32'h0;   sizes[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      run_load(addrs[i], sizes[i], 1'b1, 32'hFFFFFFFF, 0, d, e, ma, mr, lat);
      checks++;
      if (e !== 1'b1 || d !== 32'd0 || mr !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL misaligned_%0d got err %b data %h rd %b lat %0d want 1 00000000 0 1", i, e, d, mr, lat);
      end
    end
    run_load(32'h10, 2'd0, 1'b0, 32'h000000AB, 0, d, e, ma, mr, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'h000000AB) begin
      errors++;
      $display("FAIL err_clear got err %b data %h want 0 000000AB", e, d);
    end
  endtask

  task automatic test_stall();
    int bad_mem = 0;
    int bad_rsp = 0;
    int extra   = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_addr = 32'h202; bus.req_size = 2'd1; bus.req_signed = 0;
    @(posedge clk); #1;
    bus.req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h200 || bus.rsp_valid !== 1'b0) bad_mem++;
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h80011234;
    @(negedge clk);
    bus.mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h00008001 || bus.mem_rd !== 1'b0) bad_rsp++;
      @(negedge clk);
    end
    checks++; if (bad_mem != 0) begin errors++; $display("FAIL stall_mem got %0d unstable cycles want 0", bad_mem); end
    checks++; if (bad_rsp != 0) begin errors++; $display("FAIL stall_rsp got %0d unstable cycles want 0", bad_rsp); end
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0) extra++;
      @(negedge clk);
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL stall_single_rsp got %0d extra valid cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    int acc_cyc [4];
    int issued = 0;
    int got    = 0;
    int bad_data = 0;
    int bad_gap  = 0;
    exp[0] = 32'h0000000C; exp[1] = 32'hFFFFFFFD; exp[2] = 32'hFFFFFF8E; exp[3] = 32'h00000078;
    @(negedge clk);
    bus.mem_ack = 1; bus.mem_rdata = 32'h788EFD0C; bus.rsp_ready = 1;
    bus.req_valid = 1; bus.req_size = 2'd0; bus.req_signed = 1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.req_addr = 32'h10 + 32'(issued);
      if (bus.rsp_valid === 1'b1) begin
        if (bus.rsp_data !== exp[got]) bad_data++;
        got++;
      end
      if (bus.req_ready === 1'b1 && issued < 4) begin
        acc_cyc[issued] = cyc;
        if (issued > 0 && cyc - acc_cyc[issued-1] != 3) bad_gap++;
        issued++;
        if (issued == 4) begin
          @(posedge clk); #1;
          bus.req_valid = 0;
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 0; bus.mem_ack = 0; bus.rsp_ready = 0;
    checks++; if (got != 4 || issued != 4) begin errors++; $display("FAIL b2b_count got %0d rsp %0d req want 4 4", got, issued); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL b2b_order got %0d wrong responses want 0", bad_data); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap got %0d bad spacings want 0", bad_gap); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_mem();
    int spurious = 0;
    logic [31:0] d, ma;
    logic        e, mr;
    int          lat;
    @(negedge clk);
    bus.req_valid = 1; bus.req_addr = 32'h300; bus.req_size = 2'd2; bus.req_signed = 0;
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL rstmem_pre got mem_rd %b want 1", bus.mem_rd); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_rd !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmem_async got mem_rd %b ready %b want 0 1", bus.mem_rd, bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.mem_rd !== 1'b0) spurious++;
      @(negedge clk);
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmem_late_ack got %0d spurious cycles want 0", spurious); end
    run_load(32'h304, 2'd1, 1'b1, 32'h1234ABCD, 1, d, e, ma, mr, lat);
    checks++; if (d !== 32'hFFFFABCD || e !== 1'b0 || lat != 3) begin errors++; $display("FAIL rstmem_next got %h err %b lat %0d want FFFFABCD 0 3", d, e, lat); end
  endtask

  initial begin
    test_reset();
    test_byte_sweep();
    test_half_word();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_in_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ldsel_ctrl.md
# ldsel_ctrl

Load-path controller for the 32-bit memory read port. It accepts one load request at a time, issues a word-aligned read to memory, and waits for a variable-latency acknowledge. It then extracts the addressed byte, halfword or word, zero- or sign-extends it to 32 bits, and presents the result on a valid/ready response port. It sits between the core's load/store issue logic and the data memory, and owns lane selection and extension for every load.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte-address width (minimum 3).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend; ignored for word loads.
- mem_rd  out  1  memory read strobe, held until acknowledged.
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] forced to 0.
- mem_ack  in  1  memory read data valid this cycle.
- mem_rdata  in  32  memory read data, little-endian lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  extended load result.
- rsp_err  out  1  misaligned or reserved-size request.

## Operation

- The FSM has three states: IDLE, MEM and RSP. All outputs are registered except req_ready, which is 1 exactly when the state is IDLE.
- **IDLE:** a request is accepted when req_valid=1. The controller latches addr[1:0], size and signed.
  - A request is bad when size=3, when size=1 with addr[0]=1, or when size=2 with addr[1:0]≠0.
  - Bad request: go to RSP with rsp_err=1 and rsp_data=0. No memory access is made.
  - Good request: go to MEM with mem_rd=1 and mem_addr={addr[ADDR_WIDTH-1:2],2'b00}.
- **MEM:** mem_rd stays 1 and mem_addr stays stable until mem_ack=1. On mem_ack, rsp_data is captured from mem_rdata, mem_rd drops to 0 and the FSM goes to RSP.
- **RSP:** rsp_valid=1, and rsp_data and rsp_err are held stable. When rsp_ready=1, rsp_valid drops to 0 and the FSM goes to IDLE. A new request cannot be accepted in that same cycle.
- **Lane selection for bytes:** addr[1:0]=0,1,2,3 selects bits [7:0], [15:8], [23:16], [31:24].
- **Lane selection for halfwords:** addr[1]=0 selects [15:0]; addr[1]=1 selects [31:16].
- **Extension:** when signed=1, the MSB of the selected lane fills the upper bits. When signed=0, the upper bits are zero. Word loads pass mem_rdata through unchanged.
- mem_ack outside MEM is ignored and causes no state change.
- rsp_err is cleared on the next accepted request.

## Timing

- **Reset values:** state=IDLE, req_ready=1, mem_rd=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0. Reset takes effect immediately, without waiting for a clock edge.
- **Reset during MEM or RSP:** the transaction is dropped and mem_rd falls asynchronously. A late mem_ack after reset is ignored.
- **Good-request latency:**
  - Request accepted at edge N.
  - mem_rd=1 from N.
  - mem_ack sampled at edge N+k (k≥1).
  - rsp_valid=1 after edge N+k.
  - Minimum request-to-response is 2 edges.
- **Bad-request latency:** rsp_valid=1 after the accept edge (1 edge).
- **Throughput:** at most one load per 3 cycles with zero-wait memory and rsp_ready tied high.
- **Response backpressure:** rsp_ready low holds RSP indefinitely, with no data change.
- **Memory stall:** mem_ack low holds MEM indefinitely, with mem_rd and mem_addr stable.

## Test plan

- Byte loads, sweep: mem_rdata=32'h788EFD0C, size=0, addr low bits 0..3, signed 0/1. Expect 0000000C/0000000C, 000000FD/FFFFFFFD, 0000008E/FFFFFF8E, 00000078/00000078.
- Halfword and word: mem_rdata=32'h788EFD0C.
  - size=1, addr=0x102, signed=1 → 0000788E, with mem_addr=0x100.
  - size=1, addr=0x100, signed=1 → FFFFFD0C; with signed=0 → 0000FD0C.
  - size=2, addr=0x104 → 788EFD0C.
- Misaligned: size=2 addr=0x101, size=1 addr=0x103, size=3 addr=0 → each gives rsp_err=1 and rsp_data=0 one edge after accept, with mem_rd never asserted.
- Stalls: mem_ack delayed 5 cycles and rsp_ready low 3 cycles → mem_rd/mem_addr and rsp_valid/rsp_data remain stable throughout, then exactly one response is delivered.
- Back-to-back: req_valid held high for 4 requests with zero-wait memory and rsp_ready=1 → req_ready pulses once per 3 cycles and the responses come back in order.
- Reset in MEM: assert rst while mem_rd=1, then pulse mem_ack after release → mem_rd=0 immediately, no rsp_valid is produced, and the next request completes normally.
